cordic_nms: RTL

- Non-maximum suppression and threshold stage for the Sobel edge path.
- Sits directly downstream of the Cordic total-rotation stage and consumes its per-pixel gradient magnitude and angle stream.
- Quantises each angle to one of 4 gradient directions, buffers two lines to form a 3x3 magnitude window, and keeps the centre pixel only if it is a local maximum along its gradient direction and above a threshold.
- Emits a thinned edge stream with the same vsync/hsync framing as its input.

---
 rtl/cordic_nms.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/cordic_nms.sv
// cordic_nms: non-maximum suppression + threshold for the Sobel edge path.
// Latency: 3 clocks from any din_* sample to the matching dout_* slot.
// Backpressure: none; a pixel is accepted every clock while din_hsync is high.
// Ports: clk/rst_n (async active-low); din_vsync/din_hsync framing with
//   din_radians (gradient magnitude) and din_angle (2^AW = 360 deg);
//   dout_vsync/dout_hsync framing delayed 3 clocks, dout_edge flags a
//   retained edge and dout_mag carries its centre magnitude (else 0).
module cordic_nms #(
  parameter int IMG_W  = 640,
  parameter int DW     = 16,
  parameter int AW     = 20,
  parameter int THRESH = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din_vsync,
  input  logic          din_hsync,
  input  logic [DW-1:0] din_radians,
  input  logic [AW-1:0] din_angle,
  output logic          dout_vsync,
  output logic          dout_hsync,
  output logic          dout_edge,
  output logic [DW-1:0] dout_mag
);
  localparam int CW = $clog2(IMG_W + 1);
  localparam int LW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int EW = DW + 2;
  // Half a 45-degree bin (22.5 deg) in the folded AW-1 bit angle domain.
  localparam logic [AW-2:0] HALF_BIN = {2'b00, 1'b1, {(AW-4){1'b0}}};
  localparam logic [CW-1:0] COL_END  = CW'(IMG_W);
  localparam logic [DW-1:0] THR      = DW'(THRESH);

  // ---------------- input-side counters and frame qualification ----------
  logic [CW-1:0] col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic          hs_prev_q, hs_prev_d;
  logic          vs_prev_q, vs_prev_d;
  logic          frame_ok_q, frame_ok_d;
  logic          vs_rise, in_range, wr_en;

  always_comb begin
    vs_rise    = din_vsync & ~vs_prev_q;
    in_range   = (col_q < COL_END);
    wr_en      = din_hsync & in_range;
    col_d      = '0;
    if (din_hsync) col_d = in_range ? col_q + 1'b1 : col_q;
    row_d = row_q;
    if (!din_vsync) row_d = '0;
    else if (hs_prev_q && !din_hsync && row_q != 2'd3) row_d = row_q + 2'd1;
    hs_prev_d  = din_hsync;
    vs_prev_d  = din_vsync;
    // After a reset nothing is emitted until a fresh frame start is seen.
    frame_ok_d = frame_ok_q | vs_rise;
  end

  // ---------------- direction quantisation --------------------------------
  // Fold to [0,180), shift by half a bin so boundaries round into the
  // higher bin, and take the top two bits as the 45-degree bin index.
  logic [AW-2:0] dir_sum;
  logic [1:0]    din_dir;
  assign dir_sum = din_angle[AW-2:0] + HALF_BIN;
  assign din_dir = dir_sum[AW-2:AW-3];

  // ---------------- line buffers (rows r-1 and r-2) -----------------------
  logic [EW-1:0] lb0_mem [IMG_W];
  logic [EW-1:0] lb1_mem [IMG_W];
  logic [LW-1:0] rd_addr;
  logic [EW-1:0] lb0_rd, lb1_rd;

  assign rd_addr = col_q[LW-1:0];
  assign lb0_rd  = lb0_mem[rd_addr];
  assign lb1_rd  = lb1_mem[rd_addr];

  // Storage only; stale contents are masked by the row/column gating.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb0_mem[rd_addr] <= {din_dir, din_radians};
      lb1_mem[rd_addr] <= lb0_rd;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{din_angle[AW-1], dir_sum[AW-4:0], lb1_rd[EW-1:DW]};

  // ---------------- stage 1: 3x3 window columns ---------------------------
  // Index [0] = row r-2 (up), [1] = row r-1 (centre), [2] = row r (down).
  // w0 = column c, w1 = column c-1 (centre), w2 = column c-2.
  logic [2:0][DW-1:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic [1:0]         d0_q, d0_d, d1_q, d1_d;
  logic               v1_q, v1_d, hs1_q, hs1_d, vs1_q, vs1_d;

  always_comb begin
    w0_d  = {din_radians, lb0_rd[DW-1:0], lb1_rd[DW-1:0]};
    w1_d  = w0_q;
    w2_d  = w1_q;
    d0_d  = lb0_rd[EW-1:DW];
    d1_d  = d0_q;
    hs1_d = din_hsync;
    vs1_d = din_vsync;
    v1_d  = din_hsync & din_vsync & (frame_ok_q | vs_rise) & in_range &
            (row_q >= 2'd2) & (col_q >= CW'(2));
  end

  // ---------------- stage 2: suppression and threshold --------------------
  logic [DW-1:0] ctr, nb_a, nb_b;
  logic          edge2_q, edge2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [DW-1:0] mag2_q, mag2_d;

  always_comb begin
    ctr = w1_q[1];
    case (d1_q)
      2'd0:    begin nb_a = w2_q[1]; nb_b = w0_q[1]; end // left / right
      2'd1:    begin nb_a = w0_q[0]; nb_b = w2_q[2]; end // up-right / down-left
      2'd2:    begin nb_a = w1_q[0]; nb_b = w1_q[2]; end // up / down
      default: begin nb_a = w2_q[0]; nb_b = w0_q[2]; end // up-left / down-right
    endcase
    // Ties are kept, so flat plateaus survive.
    edge2_d = v1_q & (ctr >= nb_a) & (ctr >= nb_b) & (ctr > THR);
    mag2_d  = edge2_d ? ctr : '0;
    hs2_d   = hs1_q;
    vs2_d   = vs1_q;
  end

  // ---------------- stage 3: output registers -----------------------------
  logic          edge3_q, edge3_d, hs3_q, hs3_d, vs3_q, vs3_d;
  logic [DW-1:0] mag3_q, mag3_d;

  always_comb begin
    edge3_d = hs2_q & edge2_q;
    mag3_d  = hs2_q ? mag2_q : '0;
    hs3_d   = hs2_q;
    vs3_d   = vs2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      hs_prev_q  <= 1'b0;
      vs_prev_q  <= 1'b1;  // a vsync already high at release is not a frame start
      frame_ok_q <= 1'b0;
      w0_q       <= '0;
      w1_q       <= '0;
      w2_q       <= '0;
      d0_q       <= '0;
      d1_q       <= '0;
      v1_q       <= 1'b0;
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      edge2_q    <= 1'b0;
      mag2_q     <= '0;
      hs2_q      <= 1'b0;
      vs2_q      <= 1'b0;
      edge3_q    <= 1'b0;
      mag3_q     <= '0;
      hs3_q      <= 1'b0;
      vs3_q      <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      hs_prev_q  <= hs_prev_d;
      vs_prev_q  <= vs_prev_d;
      frame_ok_q <= frame_ok_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      v1_q       <= v1_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      edge2_q    <= edge2_d;
      mag2_q     <= mag2_d;
      hs2_q      <= hs2_d;
      vs2_q      <= vs2_d;
      edge3_q    <= edge3_d;
      mag3_q     <= mag3_d;
      hs3_q      <= hs3_d;
      vs3_q      <= vs3_d;
    end
  end

  assign dout_vsync = vs3_q;
  assign dout_hsync = hs3_q;
  assign dout_edge  = edge3_q;
  assign dout_mag   = mag3_q;
endmodule
